// File: rtl/score_bcd_unit.sv
// Binary score to 4-digit BCD (double-dabble, one bit/cycle) plus session-best tracker.
// Latency: done/bcd valid SCORE_WIDTH+1 cycles after start is accepted; one IDLE cycle between conversions.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy.
module score_bcd_unit #(
    parameter int SCORE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [SCORE_WIDTH-1:0] score,
    input  logic                   clear_best,
    output logic [15:0]            bcd,
    output logic [15:0]            best_bcd,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int CW = $clog2(SCORE_WIDTH + 1);
    localparam logic [13:0] MAX_SCORE = 14'd9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [15:0]            bcd_sr;
    logic [SCORE_WIDTH-1:0] op_sr;
    logic [13:0]            op_sat;
    logic [13:0]            best_bin;
    logic                   sat_flag;

    logic                   score_big;
    logic [13:0]            sat_in;
    logic [15:0]            bcd_adj;

    always_comb begin
        score_big = (score > SCORE_WIDTH'(MAX_SCORE));
        sat_in    = score_big ? MAX_SCORE : score[13:0];
    end

    // Add-3 correction is 4-bit with no carry; a nibble >=5 lands at most on 12.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            bcd_sr   <= '0;
            op_sr    <= '0;
            op_sat   <= '0;
            best_bin <= '0;
            sat_flag <= 1'b0;
            bcd      <= '0;
            best_bcd <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        op_sat   <= sat_in;
                        op_sr    <= SCORE_WIDTH'(sat_in);
                        sat_flag <= score_big;
                        bcd_sr   <= '0;
                        cnt      <= CW'(SCORE_WIDTH);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_sr, op_sr} <= {bcd_adj[14:0], op_sr, 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    done     <= 1'b1;
                    bcd      <= bcd_sr;
                    overflow <= sat_flag;
                    busy     <= 1'b0;
                    if (op_sat > best_bin) begin
                        best_bin <= op_sat;
                        best_bcd <= bcd_sr;
                    end
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
            // A clear on the same edge as a best update must win.
            if (clear_best) begin
                best_bin <= '0;
                best_bcd <= '0;
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_unit.sv
// Directed, table-driven bench for score_bcd_unit: conversion values, latency, best tracking,
// saturation, busy lockout, back-to-back start and mid-conversion reset.
module tb_score_bcd_unit;

    localparam int SW  = 16;
    localparam int LAT = SW + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] score = '0;
    logic          clear_best = 1'b0;
    logic [15:0]   bcd;
    logic [15:0]   best_bcd;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    score_bcd_unit #(.SCORE_WIDTH(SW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .score      (score),
        .clear_best (clear_best),
        .bcd        (bcd),
        .best_bcd   (best_bcd),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] score;
        bit            clr_pre;
        bit            clr_done;
        logic [15:0]   exp_bcd;
        logic [15:0]   exp_best;
        bit            exp_ovf;
    } vec_t;

    vec_t vt[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Start one conversion and watch it for a bounded window.
    task automatic run_conv(input logic [SW-1:0] s, input bit clr_done, input logic [15:0] eb,
                            input logic [15:0] ebest, input bit eo, input string nm);
        int lat;
        int ndone;
        score = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = -1;
        ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            if (clr_done && k == LAT) clear_best = 1'b1;
            tick();
            clear_best = 1'b0;
            if (k == 1) chk({nm, "_busy_hi"}, 32'(busy), 32'd1);
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    chk({nm, "_bcd"}, 32'(bcd), 32'(eb));
                    chk({nm, "_best"}, 32'(best_bcd), 32'(ebest));
                    chk({nm, "_ovf"}, 32'(overflow), 32'(eo));
                    chk({nm, "_busy_lo"}, 32'(busy), 32'd0);
                end
            end
        end
        chk({nm, "_latency"}, 32'(lat), 32'(LAT));
        chk({nm, "_ndone"}, 32'(ndone), 32'd1);
        chk({nm, "_hold"}, 32'(bcd), 32'(eb));
    endtask

    initial begin
        int ndone;
        int first_done;
        int second_done;

        vt[0]  = '{16'd0,     1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[1]  = '{16'd1234,  1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0};
        vt[2]  = '{16'd12345, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b1};
        vt[3]  = '{16'd7,     1'b0, 1'b0, 16'h0007, 16'h9999, 1'b0};
        vt[4]  = '{16'd300,   1'b1, 1'b0, 16'h0300, 16'h0300, 1'b0};
        vt[5]  = '{16'd150,   1'b0, 1'b0, 16'h0150, 16'h0300, 1'b0};
        vt[6]  = '{16'd301,   1'b0, 1'b0, 16'h0301, 16'h0301, 1'b0};
        vt[7]  = '{16'd500,   1'b0, 1'b1, 16'h0500, 16'h0000, 1'b0};
        vt[8]  = '{16'd9999,  1'b0, 1'b0, 16'h9999, 16'h9999, 1'b0};
        vt[9]  = '{16'd10000, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b1};
        vt[10] = '{16'd65535, 1'b0, 1'b0, 16'h9999, 16'h9999, 1'b1};
        vt[11] = '{16'd58,    1'b1, 1'b0, 16'h0058, 16'h0058, 1'b0};

        // Reset with start asserted must publish nothing.
        rstn  = 1'b0;
        start = 1'b1;
        score = 16'd500;
        tick();
        tick();
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_best", 32'(best_bcd), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        start = 1'b0;
        rstn  = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].clr_pre) begin
                clear_best = 1'b1;
                tick();
                clear_best = 1'b0;
                chk($sformatf("v%0d_clr_pre", i), 32'(best_bcd), 32'h0);
            end
            run_conv(vt[i].score, vt[i].clr_done, vt[i].exp_bcd, vt[i].exp_best,
                     vt[i].exp_ovf, $sformatf("v%0d", i));
        end

        // Busy lockout: a second start and score changes mid-SHIFT are ignored.
        score = 16'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            score = (k == 5) ? 16'd99 : 16'(k * 37);
            start = (k == 5);
            tick();
            start = 1'b0;
            if (done) begin
                ndone++;
                chk("lock_bcd", 32'(bcd), 32'h0042);
            end
        end
        chk("lock_ndone", 32'(ndone), 32'd1);

        // Held start: back-to-back conversions with one IDLE cycle between.
        score       = 16'd77;
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        start = 1'b0;
        chk("held_first", 32'(first_done), 32'(LAT));
        chk("held_second", 32'(second_done), 32'(2 * LAT + 1));
        chk("held_bcd", 32'(bcd), 32'h0077);
        for (int k = 0; k < 20; k++) tick();

        // Mid-conversion reset at edge 8 of a 9999 conversion.
        score = 16'd9999;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (done) ndone++;
        end
        rstn = 1'b0;
        tick();
        chk("mrst_bcd", 32'(bcd), 32'h0);
        chk("mrst_best", 32'(best_bcd), 32'h0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        rstn = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("mrst_ndone", 32'(ndone), 32'd0);
        chk("mrst_idle_busy", 32'(busy), 32'd0);
        run_conv(16'd9999, 1'b0, 16'h9999, 16'h9999, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_bcd_unit.md
# score_bcd_unit

Sequential binary-to-BCD converter and best-score tracker between the pillar score counter and the seven-segment driver. Replaces the combinational divide/modulo chain: on each sample request it converts the binary score to four BCD digits with a shift-and-add-3 (double-dabble) datapath, one bit per cycle. It holds the latest result and the session best as 16-bit words for the upper and lower halves of the seven-segment hex word.

## Interface
- SCORE_WIDTH, 16, width of the binary score input; must be ≥14
- clk  input  1  100 MHz system clock; all logic on rising edge
- rstn  input  1  reset, synchronous and active-low
- start  input  1  sample request, level-sensitive; accepted only in IDLE
- score  input  SCORE_WIDTH  binary score, unsigned
- clear_best  input  1  one-cycle pulse; zeroes the best score
- bcd  output  16  latest converted score, digit 3 in [15:12] … digit 0 in [3:0]
- best_bcd  output  16  best score seen since reset/clear, same packing
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd updates
- overflow  output  1  last converted score exceeded 9999

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0. If start=1, latch the operand and go to SHIFT. The operand is score, or 9999 if score > 9999. Set the internal saturation flag, clear the shift register's BCD part, and load the iteration counter with SCORE_WIDTH.
- SHIFT: busy=1. Each cycle, every BCD nibble ≥5 gets +3, then the combined {BCD[15:0], operand} register shifts left by 1. The counter decrements. After the SCORE_WIDTH-th shift, go to DONE.
- DONE: busy=1. Assert done for one cycle. Load bcd from the shift register and overflow from the saturation flag. If operand (saturated binary) > best binary register, load both the best binary and best_bcd. Return to IDLE.
- Arithmetic: the add-3 on a nibble is 4-bit with no carry out. Nibble values after add-3 never exceed 12. The best comparison is unsigned on the 14-bit saturated value.
- start is ignored in SHIFT and DONE; no queueing. A held-high start reconverts back-to-back, with one IDLE cycle between conversions.
- clear_best in any state zeroes best binary and best_bcd on the next edge. If it coincides with a DONE-cycle best update, the clear wins and best stays 0. bcd still updates.
- score changing during SHIFT has no effect; only the latched operand is used.
- Reset (rstn=0 at an edge) in any state, including mid-SHIFT, forces the following next cycle:
  - state=IDLE, bcd=0, best_bcd=0, best binary=0, busy=0, done=0, overflow=0, counter=0.
  - No partial result is ever published.

## Timing
- Call the edge where start is sampled high in IDLE edge 0.
- busy is high from after edge 0 until after edge SCORE_WIDTH+1.
- done is high and bcd/best_bcd/overflow are valid after edge SCORE_WIDTH+1: 17 cycles for the default.
- The next start can be accepted at edge SCORE_WIDTH+2.
- Outputs are registered with no combinational input-to-output path.
- bcd and best_bcd hold their value between done pulses.
- Throughput: one conversion per SCORE_WIDTH+2 cycles, far faster than the 50 Hz frame tick.

## Test plan
- Reset check: drive rstn=0 for 2 cycles with start=1 and score=500. Required: bcd=0x0000, best_bcd=0x0000, busy=0, done=0, overflow=0.
- Score 0 then 1234: each start results in done exactly 17 cycles later. Required: bcd=0x0000, then bcd=0x1234, best_bcd=0x1234, overflow=0.
- Saturation: score=12345. Required: bcd=0x9999, overflow=1. A following score=7 gives bcd=0x0007, overflow=0, best_bcd stays 0x9999.
- Busy lockout: start score=42, then at cycle 5 pulse start with score=99. Required: exactly one done pulse, bcd=0x0042. score changes during SHIFT are ignored.
- Best tracking: convert 300, 150, 301, then clear_best coincident with the DONE cycle of 500. Required: best_bcd goes 0x0300, 0x0300, 0x0301, then 0x0000; bcd=0x0500.
- Mid-conversion reset: assert rstn=0 at cycle 8 of a 9999 conversion. Required: no done pulse, all outputs 0. A new start after release gives a correct result 17 cycles later.
